// File: rtl/bclk_pll_sequencer_if.sv
// Signal bundle between the BCLK PLL sequencer and the surrounding clocking logic.
// The master side requests bring-up and reports PLL lock. The slave side is the
// sequencer, which returns the PLL/audio resets and its status.
interface bclk_pll_sequencer_if;
  logic       enable;
  logic       pll_locked;
  logic       pll_rst;
  logic       audio_rst;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;
  logic [2:0] state;

  modport master (
    output enable,
    output pll_locked,
    input  pll_rst,
    input  audio_rst,
    input  ready,
    input  fault,
    input  relock_count,
    input  state
  );

  modport slave (
    input  enable,
    input  pll_locked,
    output pll_rst,
    output audio_rst,
    output ready,
    output fault,
    output relock_count,
    output state
  );
endinterface

// File: rtl/bclk_pll_sequencer.sv
// Power-up and recovery sequencer for the audio bit-clock PLL.
// Runs on the 50 MHz reference clock and holds the PLL in reset for a fixed pulse.
// It then waits for a synchronized lock and requires that lock to stay stable
// before releasing the audio domain. On loss of lock while running, it
// re-sequences the PLL. If repeated lock attempts time out, it latches a fault
// until enable is dropped or rst is asserted.
module bclk_pll_sequencer #(
  parameter int RST_PULSE_CYCLES    = 100,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  bclk_pll_sequencer_if.slave   bus
);

  // One shared cycle counter serves every timed state, so it is sized for the longest.
  localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                             CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W     = $clog2(MAX_RETRIES + 1);

  // Terminal counts: the counter starts at zero on state entry.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RESET = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABILIZE = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] rty_q, rty_d, rty_inc;
  logic [7:0]       relock_q, relock_d;
  logic             lk_p0, lk_p1;
  logic             lk;
  logic             pll_rst_q, audio_rst_q, ready_q, fault_q;

  // Relock event counter saturates rather than wrapping, so a flapping PLL stays visible.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Output pattern {pll_rst, audio_rst, ready, fault} for a given state.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      S_IDLE,
      S_PLL_RESET: decode = 4'b1100;
      S_WAIT_LOCK,
      S_STABILIZE: decode = 4'b0100;
      S_RUN:       decode = 4'b0010;
      S_FAULT:     decode = 4'b1101;
      default:     decode = 4'b1100;
    endcase
  endfunction

  // --- stage p0/p1: two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_p0 <= 1'b0;
      lk_p1 <= 1'b0;
    end else begin
      lk_p0 <= bus.pll_locked;
      lk_p1 <= lk_p0;
    end
  end

  assign lk      = lk_p1;
  assign rty_inc = rty_q + RTY_W'(1);

  // Next-state, counter, retry and relock bookkeeping; enable low overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rty_d    = rty_q;
    relock_d = relock_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rty_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
        end
        S_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as lock: no retry charged.
          if (lk) begin
            state_d = S_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d   = '0;
            rty_d   = rty_inc;
            state_d = (rty_inc == RTY_LIMIT) ? S_FAULT : S_PLL_RESET;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABILIZE: begin
          // A glitch only restarts the lock wait; it is not a failed attempt.
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            rty_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lk) begin
            state_d  = S_PLL_RESET;
            cnt_d    = '0;
            relock_d = sat_inc8(relock_q);
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rty_d   = '0;
        end
      endcase
    end
  end

  // --- stage p2: state, counters and outputs; outputs decode the incoming state
  // so they change on the same edge as the state they describe.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rty_q       <= '0;
      relock_q    <= 8'd0;
      pll_rst_q   <= 1'b1;
      audio_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rty_q    <= rty_d;
      relock_q <= relock_d;
      {pll_rst_q, audio_rst_q, ready_q, fault_q} <= decode(state_d);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.audio_rst    = audio_rst_q;
  assign bus.ready        = ready_q;
  assign bus.fault        = fault_q;
  assign bus.relock_count = relock_q;
  assign bus.state        = state_q;

endmodule
